// File: rtl/isi_hist_writer.sv
`default_nettype none
// ============================================================================
// Module   : isi_hist_writer
// Purpose  : Measures inter-spike intervals of chip requests (in tick_low units)
//            and accumulates them as a histogram in an internal RAM.
// Option   : ISI_OVF_BIN_EN - also bin saturated-ISI events into the top bin
// Revision : 1.0 - initial release
// ============================================================================
module isi_hist_writer #(
    parameter int BIT_ISI  = 8,
    parameter int BIT_CNT  = 16,
    parameter int BIT_DROP = 8
) (
    input  logic                clk_main,
    input  logic                rst,
    input  logic                tick_low,
    input  logic                request_z,
    input  logic                clr_hist,
    input  logic                rd_en,
    input  logic [BIT_ISI-1:0]  rd_addr,
    output logic                rd_ready,
    output logic [BIT_CNT-1:0]  rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic [BIT_DROP-1:0] drop_cnt,
    output logic [BIT_DROP-1:0] ovf_cnt
);

    localparam int                  c_DEPTH    = 2 ** BIT_ISI;
    localparam logic [BIT_ISI-1:0]  c_ISI_MAX  = {BIT_ISI{1'b1}};
    localparam logic [BIT_CNT-1:0]  c_CNT_MAX  = {BIT_CNT{1'b1}};
    localparam logic [BIT_DROP-1:0] c_DROP_MAX = {BIT_DROP{1'b1}};
`ifdef ISI_OVF_BIN_EN
    localparam logic                c_OVF_BIN  = 1'b1;
`else
    localparam logic                c_OVF_BIN  = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_CLR     = 3'd0,
        S_IDLE    = 3'd1,
        S_RMW_RD  = 3'd2,
        S_RMW_WR  = 3'd3,
        S_HRD     = 3'd4,
        S_HRD_OUT = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync3;
    logic [BIT_ISI-1:0]   r_isi_cnt;
    logic                 r_armed;
    logic                 r_pending;
    logic [BIT_ISI-1:0]   r_pending_bin;
    logic [BIT_ISI-1:0]   r_clr_addr;
    logic [BIT_ISI-1:0]   r_rd_addr;
    logic [BIT_DROP-1:0]  r_drop_cnt;
    logic [BIT_DROP-1:0]  r_ovf_cnt;
    logic [BIT_CNT-1:0]   r_rd_data;
    logic                 r_rd_valid;
    logic [BIT_CNT-1:0]   r_q;
    logic [BIT_CNT-1:0]   r_mem [c_DEPTH];

    logic                 w_ev;
    logic                 w_isi_sat;
    logic                 w_in_clr;
    logic                 w_idle_free;
    logic                 w_clr_start;
    logic                 w_rd_accept;
    logic                 w_ev_arm;
    logic                 w_ev_meas;
    logic                 w_ev_drop;
    logic                 w_ev_ovf;
    logic                 w_ev_bin;
    logic                 w_ram_we;
    logic [BIT_ISI-1:0]   w_ram_addr;
    logic [BIT_CNT-1:0]   w_ram_wdata;

    // Request is asynchronous to clk_main: two flops to resolve metastability,
    // a third to detect the rising edge.
    always_ff @(posedge clk_main or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= request_z;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_ev        = r_sync2 & ~r_sync3;
    assign w_isi_sat   = (r_isi_cnt == c_ISI_MAX);
    assign w_in_clr    = (r_state == S_CLR);
    assign w_idle_free = (r_state == S_IDLE) && !r_pending;
    assign w_clr_start = w_idle_free && clr_hist;
    assign w_rd_accept = w_idle_free && !clr_hist && rd_en;

    // A clear starting this cycle disarms, so a coincident event is not binned.
    assign w_ev_arm  = w_ev && (w_in_clr || !r_armed);
    assign w_ev_meas = w_ev && !w_in_clr && r_armed && !w_clr_start;
    assign w_ev_drop = w_ev_meas && r_pending;
    assign w_ev_ovf  = w_ev_meas && !r_pending && w_isi_sat;
    assign w_ev_bin  = w_ev_meas && !r_pending && (c_OVF_BIN || !w_isi_sat);

    always_ff @(posedge clk_main or negedge rst) begin
        if (!rst) begin
            r_isi_cnt <= '0;
        end else if (w_ev) begin
            r_isi_cnt <= '0;
        end else if (tick_low && !w_isi_sat) begin
            r_isi_cnt <= r_isi_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_main or negedge rst) begin
        if (!rst) begin
            r_armed       <= 1'b0;
            r_pending     <= 1'b0;
            r_pending_bin <= '0;
        end else begin
            if (w_clr_start) begin
                r_armed <= 1'b0;
            end else if (w_ev_arm) begin
                r_armed <= 1'b1;
            end
            if (w_ev_bin) begin
                r_pending     <= 1'b1;
                r_pending_bin <= r_isi_cnt;
            end else if (r_state == S_RMW_WR) begin
                r_pending     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_main or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else if (w_clr_start) begin
            r_drop_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_ev_drop && (r_drop_cnt != c_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_ev_ovf && (r_ovf_cnt != c_DROP_MAX)) begin
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_main or negedge rst) begin
        if (!rst) begin
            r_state    <= S_CLR;
            r_clr_addr <= '0;
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_valid <= (r_state == S_HRD_OUT);
            if (w_clr_start) begin
                r_clr_addr <= '0;
            end else if (w_in_clr) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_addr <= rd_addr;
            end
            if (r_state == S_HRD_OUT) begin
                r_rd_data <= r_q;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLR: begin
                if (r_clr_addr == c_ISI_MAX) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (r_pending) begin
                    w_state_nxt = S_RMW_RD;
                end else if (clr_hist) begin
                    w_state_nxt = S_CLR;
                end else if (rd_en) begin
                    w_state_nxt = S_HRD;
                end
            end
            S_RMW_RD:  w_state_nxt = S_RMW_WR;
            S_RMW_WR:  w_state_nxt = S_IDLE;
            S_HRD:     w_state_nxt = S_HRD_OUT;
            S_HRD_OUT: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_CLR;
        endcase
    end

    // Single RAM port shared by the clear sweep, the RMW update and host reads.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = r_rd_addr;
        w_ram_wdata = '0;
        case (r_state)
            S_CLR: begin
                w_ram_we   = 1'b1;
                w_ram_addr = r_clr_addr;
            end
            S_RMW_RD: begin
                w_ram_addr = r_pending_bin;
            end
            S_RMW_WR: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_pending_bin;
                w_ram_wdata = (r_q == c_CNT_MAX) ? r_q : r_q + 1'b1;
            end
            default: begin
                w_ram_addr = r_rd_addr;
            end
        endcase
    end

    always_ff @(posedge clk_main) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
        r_q <= r_mem[w_ram_addr];
    end

    assign rd_ready = w_idle_free;
    assign busy     = (r_state != S_IDLE);
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign drop_cnt = r_drop_cnt;
    assign ovf_cnt  = r_ovf_cnt;

endmodule
`default_nettype wire
